// File: rtl/uart_reg_frame_rx.sv
// Framed command receiver: decodes SOF/ADDR/payload/CSUM frames from a UART byte
// stream, writes addressed channel registers and queues a one-byte ACK/NAK reply.
module uart_reg_frame_rx #(
  parameter int          CHANNEL_COUNT  = 4,
  parameter int          BYTES_PER_CH   = 2,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int          ERR_W          = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ena,
  input  logic [7:0]                            rx_data,
  input  logic                                  rx_valid,
  output logic [CHANNEL_COUNT*8*BYTES_PER_CH-1:0] ch_data,
  output logic [CHANNEL_COUNT-1:0]              ch_update,
  output logic [7:0]                            tx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  output logic [ERR_W-1:0]                      err_count,
  output logic                                  resp_overrun
);

  localparam int W  = 8 * BYTES_PER_CH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (BYTES_PER_CH > 1) ? $clog2(BYTES_PER_CH) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} state_t;

  state_t        state;
  logic [7:0]    addr;
  logic [7:0]    csum;
  logic [IW-1:0] idx;
  logic [W-1:0]  shadow;
  logic [TW-1:0] tmo;

  logic          frame_end;
  logic          accept;
  logic          timeout_hit;
  logic          resp_req;
  logic [7:0]    resp_code;
  logic [31:0]   addr_ext;

  // Frame-completion, timeout and response-request decode for the current edge.
  always_comb begin
    addr_ext    = {24'h000000, addr};
    frame_end   = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    if (ena && rx_valid && (state == CSUM)) begin
      frame_end = 1'b1;
      accept    = (rx_data == csum) && (addr_ext < CHANNEL_COUNT);
    end else begin
      frame_end = 1'b0;
    end
    if (ena && !rx_valid && (state != IDLE) && (tmo == TW'(TIMEOUT_CYCLES - 1))) begin
      timeout_hit = 1'b1;
    end else begin
      timeout_hit = 1'b0;
    end
    resp_req  = frame_end | timeout_hit;
    resp_code = accept ? ACK_BYTE : NAK_BYTE;
  end

  // Frame FSM, channel registers, timeout counter, statistics and response buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= 8'h00;
      csum         <= 8'h00;
      idx          <= '0;
      shadow       <= '0;
      tmo          <= '0;
      ch_data      <= '0;
      ch_update    <= '0;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      err_count    <= '0;
      resp_overrun <= 1'b0;
    end else if (ena) begin
      ch_update <= '0;
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == SOF_BYTE)) begin
            state <= ADDR;
          end
        end
        ADDR: begin
          if (rx_valid) begin
            addr  <= rx_data;
            csum  <= rx_data;
            idx   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (rx_valid) begin
            for (int b = 0; b < BYTES_PER_CH; b++) begin
              if (idx == IW'(b)) begin
                shadow[b*8 +: 8] <= rx_data;
              end
            end
            csum <= csum ^ rx_data;
            if (idx == IW'(BYTES_PER_CH - 1)) begin
              state <= CSUM;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        CSUM: begin
          if (rx_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Only the addressed channel is touched on an accepted frame.
      if (accept) begin
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
          if (addr_ext == 32'(k)) begin
            ch_data[k*W +: W] <= shadow;
            ch_update[k]      <= 1'b1;
          end
        end
      end

      if (rx_valid || (state == IDLE) || timeout_hit) begin
        tmo <= '0;
      end else begin
        tmo <= tmo + TW'(1);
      end
      if (timeout_hit) begin
        state <= IDLE;
      end

      if (resp_req && !accept && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + ERR_W'(1);
      end

      // Depth-1 reply buffer; a transfer in the same cycle frees the slot.
      if (resp_req) begin
        if (!tx_valid || tx_ready) begin
          tx_valid <= 1'b1;
          tx_data  <= resp_code;
        end else begin
          resp_overrun <= 1'b1;
        end
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end else begin
      ch_update <= '0;
    end
  end

endmodule

// File: tb/tb_uart_reg_frame_rx.sv
// Self-checking bench: frame-level reference model compared every cycle, plus
// hand-computed expectations for the directed frames.
module tb_uart_reg_frame_rx;

  localparam int CH  = 4;
  localparam int BPC = 2;
  localparam int TO  = 20;
  localparam int W   = 8 * BPC;
  localparam logic [7:0] SOF = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ena;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [CH*W-1:0] ch_data;
  logic [CH-1:0]   ch_update;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [7:0]      err_count;
  logic            resp_overrun;

  int checks = 0;
  int errors = 0;

  uart_reg_frame_rx #(
    .CHANNEL_COUNT(CH), .BYTES_PER_CH(BPC), .TIMEOUT_CYCLES(TO),
    .SOF_BYTE(SOF), .ACK_BYTE(ACK), .NAK_BYTE(NAK), .ERR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx_data(rx_data), .rx_valid(rx_valid),
    .ch_data(ch_data), .ch_update(ch_update), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .err_count(err_count), .resp_overrun(resp_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects whole frames and judges them as a unit.
  logic [W-1:0] m_ch [CH];
  logic [CH-1:0] m_upd;
  logic          m_txv;
  logic [7:0]    m_txd;
  int            m_err;
  logic          m_ovr;
  logic [7:0]    fq[$];
  int            gap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) m_ch[k] = '0;
      m_upd = '0; m_txv = 1'b0; m_txd = 8'h00; m_err = 0; m_ovr = 1'b0;
      fq.delete(); gap = 0;
    end else if (ena) begin
      bit resp;
      logic [7:0] code;
      logic [7:0] x;
      logic [W-1:0] pl;
      resp = 1'b0; code = NAK; m_upd = '0;
      if (rx_valid) begin
        gap = 0;
        if (fq.size() != 0 || rx_data == SOF) fq.push_back(rx_data);
        if (fq.size() == BPC + 3) begin
          x = 8'h00;
          for (int i = 1; i <= BPC + 1; i++) x = x ^ fq[i];
          for (int b = 0; b < BPC; b++) pl[b*8 +: 8] = fq[2+b];
          resp = 1'b1;
          if (x == fq[BPC+2] && int'(fq[1]) < CH) begin
            m_ch[fq[1]] = pl;
            m_upd[fq[1]] = 1'b1;
            code = ACK;
          end else begin
            code = NAK;
            if (m_err < 255) m_err++;
          end
          fq.delete();
        end
      end else if (fq.size() != 0) begin
        gap++;
        if (gap == TO) begin
          resp = 1'b1; code = NAK;
          if (m_err < 255) m_err++;
          fq.delete(); gap = 0;
        end
      end
      if (resp) begin
        if (!m_txv || tx_ready) begin m_txv = 1'b1; m_txd = code; end
        else m_ovr = 1'b1;
      end else if (m_txv && tx_ready) begin
        m_txv = 1'b0;
      end
    end else begin
      m_upd = '0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [CH*W-1:0] flat;
      for (int k = 0; k < CH; k++) flat[k*W +: W] = m_ch[k];
      check("cyc_ch_data", 64'(ch_data), 64'(flat));
      check("cyc_ch_update", 64'(ch_update), 64'(m_upd));
      check("cyc_tx_valid", 64'(tx_valid), 64'(m_txv));
      check("cyc_tx_data", 64'(tx_data), 64'(m_txd));
      check("cyc_err_count", 64'(err_count), 64'(m_err));
      check("cyc_overrun", 64'(resp_overrun), 64'(m_ovr));
    end
  end

  logic [7:0] sent_q[$];
  always @(posedge clk) begin
    if (rst_n && ena && tx_valid && tx_ready) sent_q.push_back(tx_data);
  end

  function automatic logic [7:0] first_sent();
    return (sent_q.size() > 0) ? sent_q[0] : 8'hXX;
  endfunction

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drive(input logic [7:0] b);
    tick(); rx_valid = 1'b1; rx_data = b;
  endtask

  task automatic rx_off();
    tick(); rx_valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4);
    drive(b0); drive(b1); drive(b2); drive(b3); drive(b4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    #3;
    check("rst_ch_data", 64'(ch_data), 64'h0);
    check("rst_tx_valid", 64'(tx_valid), 64'h0);
    check("rst_err", 64'(err_count), 64'h0);
    tick(); rst_n = 1'b1;

    // Valid frame to channel 2; checksum is 02^34^12 = 24.
    send5(8'hA5, 8'h02, 8'h34, 8'h12, 8'h24); rx_off();
    check("f1_ch2", 64'(ch_data[47:32]), 64'h1234);
    check("f1_update", 64'(ch_update), 64'h4);
    check("f1_tx_data", 64'(tx_data), 64'h06);
    check("f1_err", 64'(err_count), 64'h0);
    tick();
    check("f1_update_gone", 64'(ch_update), 64'h0);
    check("f1_sent_n", 64'(sent_q.size()), 64'd1);
    check("f1_sent", 64'(first_sent()), 64'h06);
    sent_q.delete();

    // Bad checksum.
    send5(8'hA5, 8'h01, 8'hAA, 8'h55, 8'h00); rx_off();
    check("bad_update", 64'(ch_update), 64'h0);
    check("bad_tx", 64'(tx_data), 64'h15);
    check("bad_err", 64'(err_count), 64'h1);
    tick();
    check("bad_sent", 64'(first_sent()), 64'h15);
    sent_q.delete();

    // Address out of range with a matching checksum.
    send5(8'hA5, 8'h07, 8'h00, 8'h00, 8'h07); rx_off();
    check("oor_data", 64'(ch_data), 64'h0000_1234_0000_0000);
    check("oor_tx", 64'(tx_data), 64'h15);
    check("oor_err", 64'(err_count), 64'h2);

    // Stall after A5 03 11: the NAK lands on the TO-th idle cycle.
    drive(8'hA5); drive(8'h03); drive(8'h11); rx_off();
    repeat (TO - 1) tick();
    check("tmo_early_err", 64'(err_count), 64'h2);
    check("tmo_early_txv", 64'(tx_valid), 64'h0);
    tick();
    check("tmo_err", 64'(err_count), 64'h3);
    check("tmo_tx", 64'(tx_data), 64'h15);
    check("tmo_txv", 64'(tx_valid), 64'h1);
    send5(8'hA5, 8'h03, 8'h11, 8'h22, 8'h30); rx_off();
    check("tmo_next_ch3", 64'(ch_data), 64'h2211_1234_0000_0000);
    check("tmo_next_upd", 64'(ch_update), 64'h8);

    // ena low mid-frame: a strobe during ena low is ignored; CSUM = 00^CD^AB = 66.
    drive(8'hA5); drive(8'h00); drive(8'hCD); drive(8'hAB);
    tick(); ena = 1'b0; rx_valid = 1'b1; rx_data = 8'hFF;
    tick(); tick(); ena = 1'b1; rx_valid = 1'b0;
    drive(8'h66); rx_off(); ena = 1'b0;
    check("ena_ch0", 64'(ch_data[15:0]), 64'hABCD);
    tick();
    check("ena_upd_forced", 64'(ch_update), 64'h0);
    check("ena_txv_held", 64'(tx_valid), 64'h1);
    ena = 1'b1; tick(); tick();

    // Back-pressure across two accepted frames.
    tx_ready = 1'b0;
    send5(8'hA5, 8'h01, 8'h01, 8'h00, 8'h00); rx_off();
    check("bp_ovr0", 64'(resp_overrun), 64'h0);
    send5(8'hA5, 8'h01, 8'h02, 8'h00, 8'h03); rx_off();
    check("bp_ovr1", 64'(resp_overrun), 64'h1);
    check("bp_txd", 64'(tx_data), 64'h06);
    check("bp_ch1", 64'(ch_data[31:16]), 64'h0002);
    sent_q.delete();
    tx_ready = 1'b1;
    tick(); tick(); tick();
    check("bp_sent_n", 64'(sent_q.size()), 64'd1);
    check("bp_sent", 64'(first_sent()), 64'h06);

    // 256 back-to-back bad frames saturate the error counter.
    for (int i = 0; i < 256; i++) send5(8'hA5, 8'h00, 8'h00, 8'h00, 8'hFF);
    rx_off();
    check("sat_err", 64'(err_count), 64'hFF);

    // Asynchronous reset mid-frame.
    drive(8'hA5); drive(8'h02); rx_off();
    #3 rst_n = 1'b0;
    #1;
    check("arst_ch_data", 64'(ch_data), 64'h0);
    check("arst_upd", 64'(ch_update), 64'h0);
    check("arst_txv", 64'(tx_valid), 64'h0);
    check("arst_txd", 64'(tx_data), 64'h0);
    check("arst_err", 64'(err_count), 64'h0);
    check("arst_ovr", 64'(resp_overrun), 64'h0);
    tick(); rst_n = 1'b1;
    send5(8'hA5, 8'h02, 8'h34, 8'h12, 8'h24); rx_off();
    check("post_rst_frame", 64'(ch_data), 64'h0000_1234_0000_0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
